// File: rtl/fmlbrg_cachectl.sv
// Direct-mapped write-back cache controller for the FML bridge: hit/miss decision,
// 4-beat evict/refill burst sequencing, tag memory updates and requester ack.
module fmlbrg_cachectl #(
  parameter int adr_width   = 26,
  parameter int cache_depth = 9
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               req_stb,
  input  logic                               req_we,
  input  logic [adr_width-1:0]               req_adr,
  output logic                               ack,
  output logic [cache_depth-1:0]             tag_a,
  output logic                               tag_we,
  output logic [adr_width-cache_depth-5+1:0] tag_di,
  input  logic [adr_width-cache_depth-5+1:0] tag_do,
  output logic [adr_width-1:0]               fml_adr,
  output logic                               fml_stb,
  output logic                               fml_we,
  input  logic                               fml_ack,
  output logic                               evict_en,
  output logic                               refill_en,
  output logic [1:0]                         beat
);
  localparam int TW = adr_width - cache_depth - 5;

  typedef enum logic [2:0] {IDLE, TEST, EVICT, REFILL, WRTAG} state_t;

  state_t                     state, state_n;
  logic [adr_width-6:0]       lat_adr;   // latched line address (byte offset dropped)
  logic                       we_q;
  logic [TW-1:0]              evict_tag;
  logic                       bursting;
  logic [1:0]                 beat_q;
  logic                       ack_q;

  logic [cache_depth-1:0]     idx_q;
  logic [TW-1:0]              tag_q;
  logic                       tag_v, tag_d, hit;
  logic [TW-1:0]              tag_t;
  logic                       burst_st, beat_en, burst_done, accept;
  logic                       unused_ok;

  assign unused_ok  = ^req_adr[4:0];

  assign idx_q      = lat_adr[cache_depth-1:0];
  assign tag_q      = lat_adr[adr_width-6:cache_depth];
  assign tag_v      = tag_do[TW+1];
  assign tag_d      = tag_do[TW];
  assign tag_t      = tag_do[TW-1:0];
  assign hit        = tag_v && (tag_t == tag_q);

  // Beat 0 coincides with the fml_ack cycle; beats 1..3 follow from the counter.
  assign burst_st   = (state == EVICT) || (state == REFILL);
  assign beat_en    = burst_st && (bursting || fml_ack);
  assign burst_done = bursting && (beat_q == 2'd3);
  assign accept     = (state == IDLE) && req_stb && !ack_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      lat_adr   <= '0;
      we_q      <= 1'b0;
      evict_tag <= '0;
      bursting  <= 1'b0;
      beat_q    <= 2'd0;
      ack_q     <= 1'b0;
    end else begin
      state <= state_n;
      ack_q <= (state == TEST) && hit;
      if (accept) begin
        lat_adr <= req_adr[adr_width-1:5];
        we_q    <= req_we;
      end
      if (state == TEST) evict_tag <= tag_t;
      if (burst_st) begin
        if (!bursting) begin
          if (fml_ack) begin
            bursting <= 1'b1;
            beat_q   <= 2'd1;
          end
        end else if (beat_q == 2'd3) begin
          bursting <= 1'b0;
          beat_q   <= 2'd0;
        end else begin
          beat_q <= beat_q + 2'd1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    tag_we  = 1'b0;
    tag_di  = {2'b10, tag_q};
    case (state)
      IDLE:   if (accept) state_n = TEST;
      TEST: begin
        if (hit) begin
          state_n = IDLE;
          if (we_q) begin
            tag_we = 1'b1;
            tag_di = {2'b11, tag_q};
          end
        end else if (tag_v && tag_d) begin
          state_n = EVICT;
        end else begin
          state_n = REFILL;
        end
      end
      EVICT:  if (burst_done) state_n = REFILL;
      REFILL: if (burst_done) state_n = WRTAG;
      WRTAG: begin
        tag_we  = 1'b1;
        tag_di  = {2'b10, tag_q};
        state_n = TEST;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ack       = ack_q;
  assign tag_a     = (state == IDLE) ? req_adr[cache_depth+4:5] : idx_q;
  assign fml_stb   = burst_st && !bursting;
  assign fml_we    = (state == EVICT);
  assign fml_adr   = (state == EVICT) ? {evict_tag, idx_q, 5'b0} : {tag_q, idx_q, 5'b0};
  assign evict_en  = (state == EVICT) && beat_en;
  assign refill_en = (state == REFILL) && beat_en;
  assign beat      = beat_q;
endmodule
